// File: rtl/pipe_skid_buffer_pkg.sv
// Shared pipeline definitions: stage-controller FSM encoding reused by skid buffers
// and other pipeline stage controllers.
package pipe_skid_buffer_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] state_occupancy(input skid_state_e st);
        unique case (st)
            StOne:   return 2'd1;
            StFull:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_reg.sv
// W-bit data register with synchronous active-high reset and write enable.
module data_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: registered in_ready breaks the out_ready -> in_ready path while
// keeping full throughput; the skid entry absorbs the one beat in flight on a stall.
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int unsigned    W      = 16,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    skid_state_e  state_q, state_d;
    logic         in_ready_q;
    logic [1:0]   occ_q;
    logic         main_en, skid_en;
    logic [W-1:0] main_d, main_q, skid_q;
    logic         accept, retire;

    assign accept = in_valid & in_ready_q;
    assign retire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    main_en = 1'b1;
                end
            end
            StOne: begin
                if (accept && retire) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = StFull;
                    skid_en = 1'b1;
                end else if (retire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (retire) begin
                    state_d = StOne;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops everything; stale entry contents stay hidden behind out_valid=0.
        if (flush) begin
            state_d = StEmpty;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
            occ_q      <= state_occupancy(state_d);
        end
    end

    data_reg #(
        .W (W)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    data_reg #(
        .W (W)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed vector table, corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_pipe_skid_buffer;

    localparam int unsigned W   = 16;
    localparam logic [15:0] BUB = 16'h0000;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic        iv;
        logic        fl;
        logic        orr;
        logic [15:0] d;
        logic [19:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_skid_buffer #(
        .W      (W),
        .BUBBLE (BUB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    // Tuple layout: {out_valid, out_data, in_ready, occupancy}
    function automatic logic [19:0] tup(input logic v, input logic [15:0] d, input logic r,
                                        input logic [1:0] o);
        return {v, d, r, o};
    endfunction

    function automatic logic [19:0] dut_tup();
        return {out_valid, out_data, in_ready, occupancy};
    endfunction

    function automatic logic [19:0] model_tup();
        logic [15:0] d;
        d = (sb.size() != 0) ? sb[0] : BUB;
        return {sb.size() != 0, d, sb.size() < 2, 2'(sb.size())};
    endfunction

    function automatic void add(input logic iv, input logic fl, input logic orr,
                                input logic [15:0] d, input logic [19:0] exp, input string name);
        vec_t v;
        v.iv = iv; v.fl = fl; v.orr = orr; v.d = d; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got v=%b d=%h rdy=%b occ=%0d want v=%b d=%h rdy=%b occ=%0d",
                     name, act[19], act[18:3], act[2], act[1:0],
                     exp[19], exp[18:3], exp[2], exp[1:0]);
        end
    endtask

    // Drive one cycle, update the scoreboard, then compare after the edge.
    task automatic step(input logic r, input logic iv, input logic fl, input logic orr,
                        input logic [15:0] d, input logic probe);
        logic acc, ret, exp_rdy;
        rst = r; in_valid = iv; flush = fl; out_ready = orr; in_data = d;
        exp_rdy = (sb.size() < 2);
        if (probe) begin
            #2 out_ready = ~orr;
            #1 chk("in_ready_comb", {19'b0, in_ready}, {19'b0, exp_rdy});
            out_ready = orr;
        end
        acc = iv && exp_rdy;
        ret = (sb.size() != 0) && orr;
        if (r || fl) begin
            sb.delete();
        end else begin
            if (ret) void'(sb.pop_front());
            if (acc) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("model", dut_tup(), model_tup());
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset
        step(1, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 16'h0, 0);
        chk("reset", dut_tup(), tup(0, 16'h0, 1, 2'd0));
        step(0, 0, 0, 0, 16'h0, 0);
        chk("reset_release", dut_tup(), tup(0, 16'h0, 1, 2'd0));

        // Stream
        for (int i = 1; i <= 8; i++) begin
            add(1, 0, 1, 16'(i), tup(1, 16'(i), 1, 2'd1), "stream");
        end
        add(0, 0, 1, 16'h0, tup(0, BUB, 1, 2'd0), "stream_drain");
        // Backpressure
        add(1, 0, 0, 16'hAAAA, tup(1, 16'hAAAA, 1, 2'd1), "bp_a");
        add(1, 0, 0, 16'hBBBB, tup(1, 16'hAAAA, 0, 2'd2), "bp_full");
        add(1, 0, 0, 16'hCCCC, tup(1, 16'hAAAA, 0, 2'd2), "bp_hold_c");
        add(1, 0, 1, 16'hCCCC, tup(1, 16'hBBBB, 1, 2'd1), "bp_out_a");
        add(1, 0, 1, 16'hCCCC, tup(1, 16'hCCCC, 1, 2'd1), "bp_out_b");
        add(0, 0, 1, 16'h0, tup(0, BUB, 1, 2'd0), "bp_out_c");
        // Flush from FULL with a simultaneous offer
        add(1, 0, 0, 16'h1111, tup(1, 16'h1111, 1, 2'd1), "fl_a");
        add(1, 0, 0, 16'h2222, tup(1, 16'h1111, 0, 2'd2), "fl_full");
        add(1, 1, 0, 16'h3333, tup(0, BUB, 1, 2'd0), "flush");
        add(0, 0, 1, 16'h0, tup(0, BUB, 1, 2'd0), "flush_no_3333");
        // Simultaneous accept and retire in ONE
        add(1, 0, 0, 16'h0A0A, tup(1, 16'h0A0A, 1, 2'd1), "sim_a");
        add(1, 0, 1, 16'h0B0B, tup(1, 16'h0B0B, 1, 2'd1), "sim_swap");
        add(0, 0, 1, 16'h0, tup(0, BUB, 1, 2'd0), "sim_drain");

        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].iv, vecs[i].fl, vecs[i].orr, vecs[i].d, 0);
            chk(vecs[i].name, dut_tup(), vecs[i].exp);
        end

        // Reset mid-operation beats flush, accept and retire
        step(0, 1, 0, 0, 16'h5555, 0);
        step(0, 1, 0, 0, 16'h6666, 0);
        step(1, 1, 1, 1, 16'h7777, 0);
        chk("mid_reset", dut_tup(), tup(0, 16'h0, 1, 2'd0));
        step(0, 0, 0, 1, 16'h0, 0);
        chk("mid_reset_after", dut_tup(), tup(0, 16'h0, 1, 2'd0));

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 6, 16'($urandom), (i % 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The block SHALL have parameter W, default 16, data width in bits.
REQ-002 The block SHALL have parameter BUBBLE, default 0 (W bits), value driven on out_data when out_valid=0 (NOP).
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1, discard all held entries.
REQ-006 The block SHALL have port in_valid, input, 1, upstream data valid.
REQ-007 The block SHALL have port in_data, input, W, upstream data.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts data this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, downstream data valid.
REQ-010 The block SHALL have port out_data, output, W, downstream data.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts data this cycle.
REQ-012 The block SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-013 Transfers SHALL occur in: in_valid&in_ready (accept) and out_valid&out_ready (retire), evaluated at the same rising edge.
REQ-014 Storage SHALL be two W-bit entries: main (drives out_data) and skid (overflow); FSM states EMPTY (0), ONE (main only), FULL (main+skid).
REQ-015 in_ready SHALL be registered and equal to (state != FULL); no combinational path from out_ready to in_ready.
REQ-016 out_valid SHALL equal (state != EMPTY); out_data SHALL be main when valid, else BUBBLE.
REQ-017 Latency SHALL be 1 cycle: data accepted at edge N appears on out_data after edge N when block was EMPTY.
REQ-018 Throughput SHALL be one transfer per cycle in ONE with continuous in_valid and out_ready.
REQ-019 Transitions: EMPTY+accept->ONE; ONE+accept+retire->ONE (main<=in_data); ONE+accept,no retire->FULL (skid<=in_data); ONE+retire,no accept->EMPTY; FULL+retire->ONE (main<=skid); otherwise hold.
REQ-020 Ordering SHALL be strict FIFO; no entry dropped or duplicated except by flush.
REQ-021 In FULL, in_valid SHALL be ignored (in_ready=0); held data SHALL not change while out_ready=0.
REQ-022 flush SHALL force next state EMPTY, in_ready=1 next cycle, overriding any simultaneous accept or retire; data presented in the flush cycle SHALL be discarded.
REQ-023 occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL, registered.
REQ-024 Unused entry contents SHALL not be observable on any output.

Reset
REQ-025 rst SHALL have priority over flush and all transfers.
REQ-026 After reset: state EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0, main=skid=0.
REQ-027 Reset asserted mid-operation SHALL discard both entries at that edge with no output glitch afterwards.

Structure
REQ-028 The FSM state encoding (EMPTY, ONE, FULL) SHALL live in the shared pipeline package for reuse by stage controllers.
REQ-029 One sub-module SHALL be used: data_reg, a W-bit register with synchronous reset and write enable, instantiated for main and skid.
REQ-030 The design SHALL be fully synchronous to clk; no negedge logic.

Verification
REQ-031 Reset: rst=1 two cycles, then release -> out_valid=0, out_data=0, in_ready=1, occupancy=0.
REQ-032 Stream: in_valid=1 with 0x0001..0x0008 on consecutive cycles, out_ready=1 -> outputs 0x0001..0x0008 one per cycle, 1-cycle latency, occupancy stays 1.
REQ-033 Backpressure: send 0xAAAA, 0xBBBB with out_ready=0 -> occupancy=2, in_ready=0, 0xCCCC offered is held upstream; raise out_ready -> outputs 0xAAAA, 0xBBBB, 0xCCCC in order.
REQ-034 Flush: in FULL with 0x1111/0x2222, assert flush together with in_valid=1 data 0x3333 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1; 0x3333 never appears.
REQ-035 Simultaneous: in ONE holding 0x0A0A, accept 0x0B0B and retire same edge -> state ONE, out_data=0x0B0B.
REQ-036 Random: random in_valid/out_ready/flush 10k cycles vs scoreboard queue -> no loss, duplication or reorder; in_ready never depends combinationally on out_ready.
